// File: rtl/tensor_tile_sched.sv
// rtl/tensor_tile_sched.sv - GEMM tile scheduler issuing C/A/B/D DMA descriptors
module tensor_tile_sched #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int TILE   = 8,
  parameter int DIM_W  = 8,
  parameter int OUT_W  = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] cfg_base_addr_A,
  input  logic [ADDR_W-1:0] cfg_base_addr_B,
  input  logic [ADDR_W-1:0] cfg_base_addr_C,
  input  logic [ADDR_W-1:0] cfg_base_addr_D,
  input  logic [DIM_W-1:0]  cfg_m,
  input  logic [DIM_W-1:0]  cfg_n,
  input  logic [DIM_W-1:0]  cfg_k,
  input  logic              cfg_start,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  output logic [1:0]        cmd_type,
  input  logic              core_done,
  input  logic              wr_done,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int BEAT_BYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] TILE_BYTES = ADDR_W'(TILE * BEAT_BYTES);
  localparam int PW = 2 * DIM_W;

  typedef enum logic [3:0] {
    IDLE, ISSUE_C, ISSUE_A, ISSUE_B, WAIT_CORE, ISSUE_D, NEXT, DRAIN, DONE
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] base_a, base_b, base_c, base_d;
  logic [DIM_W-1:0]  m_q, n_q, k_q;
  logic [DIM_W-1:0]  mi, ni, kk, mi_n, ni_n, kk_n;
  logic [OUT_W-1:0]  out_cnt;
  logic              core_flag;

  logic              xfer, zero_dim, start_acc, busy_st, d_acc;
  logic [DIM_W-1:0]  row, col, cols;
  logic [PW-1:0]     tile_idx;
  logic [ADDR_W-1:0] base_sel, desc_addr;
  logic [1:0]        desc_type;
  logic              issue_n;

  assign xfer      = cmd_valid && cmd_ready;
  assign zero_dim  = (cfg_m == '0) || (cfg_n == '0) || (cfg_k == '0);
  assign start_acc = (state == IDLE) && cfg_start;
  assign busy_st   = (state != IDLE) && (state != DONE);
  assign d_acc     = (state == ISSUE_D) && xfer;

  always_comb begin
    state_n = state;
    mi_n    = mi;
    ni_n    = ni;
    kk_n    = kk;
    case (state)
      IDLE: begin
        if (cfg_start && !zero_dim) begin
          state_n = ISSUE_C;
          mi_n    = '0;
          ni_n    = '0;
          kk_n    = '0;
        end
      end
      ISSUE_C: if (xfer) state_n = ISSUE_A;
      ISSUE_A: if (xfer) state_n = ISSUE_B;
      ISSUE_B: begin
        if (xfer) begin
          if (kk == k_q - DIM_W'(1)) begin
            state_n = WAIT_CORE;
          end else begin
            kk_n    = kk + DIM_W'(1);
            state_n = ISSUE_A;
          end
        end
      end
      WAIT_CORE: if (core_flag) state_n = ISSUE_D;
      ISSUE_D:   if (xfer) state_n = NEXT;
      NEXT: begin
        kk_n = '0;
        if (ni == n_q - DIM_W'(1)) begin
          ni_n = '0;
          if (mi == m_q - DIM_W'(1)) begin
            state_n = DRAIN;
          end else begin
            mi_n    = mi + DIM_W'(1);
            state_n = ISSUE_C;
          end
        end else begin
          ni_n    = ni + DIM_W'(1);
          state_n = ISSUE_C;
        end
      end
      DRAIN:   if (out_cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Descriptor for the state being entered, so cmd_* can be loaded straight into flops.
  always_comb begin
    base_sel  = base_c;
    row       = mi_n;
    col       = ni_n;
    cols      = n_q;
    desc_type = 2'd2;
    issue_n   = 1'b0;
    case (state_n)
      ISSUE_C: begin
        issue_n  = 1'b1;
        base_sel = (state == IDLE) ? cfg_base_addr_C : base_c;
      end
      ISSUE_A: begin
        issue_n   = 1'b1;
        base_sel  = base_a;
        col       = kk_n;
        cols      = k_q;
        desc_type = 2'd0;
      end
      ISSUE_B: begin
        issue_n   = 1'b1;
        base_sel  = base_b;
        row       = kk_n;
        desc_type = 2'd1;
      end
      ISSUE_D: begin
        issue_n   = 1'b1;
        base_sel  = base_d;
        desc_type = 2'd3;
      end
      default: issue_n = 1'b0;
    endcase
    tile_idx  = PW'(row) * PW'(cols) + PW'(col);
    desc_addr = base_sel + ADDR_W'(tile_idx) * TILE_BYTES;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      mi        <= '0;
      ni        <= '0;
      kk        <= '0;
      m_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      base_a    <= '0;
      base_b    <= '0;
      base_c    <= '0;
      base_d    <= '0;
      out_cnt   <= '0;
      core_flag <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      cmd_type  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      mi        <= mi_n;
      ni        <= ni_n;
      kk        <= kk_n;
      cmd_valid <= issue_n;
      busy      <= (state_n != IDLE) && (state_n != DONE);
      done      <= (state_n == DONE) || (start_acc && zero_dim);
      // Issue states never loop to themselves on a transfer, so a state change marks a new descriptor.
      if (issue_n && (state_n != state)) begin
        cmd_addr <= desc_addr;
        cmd_type <= desc_type;
        cmd_len  <= 8'(TILE - 1);
      end
      if (start_acc) begin
        base_a <= cfg_base_addr_A;
        base_b <= cfg_base_addr_B;
        base_c <= cfg_base_addr_C;
        base_d <= cfg_base_addr_D;
        m_q    <= cfg_m;
        n_q    <= cfg_n;
        k_q    <= cfg_k;
        err    <= zero_dim;
      end
      if (start_acc) begin
        core_flag <= 1'b0;
      end else if ((state == WAIT_CORE) && core_flag) begin
        core_flag <= 1'b0;
      end else if (busy_st && core_done) begin
        core_flag <= 1'b1;
      end
      if (d_acc && !wr_done) begin
        out_cnt <= out_cnt + OUT_W'(1);
      end else if (!d_acc && wr_done && (out_cnt != '0)) begin
        out_cnt <= out_cnt - OUT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_tensor_tile_sched.sv
// tb/tb_tensor_tile_sched.sv - scoreboard bench for tensor_tile_sched
module tb_tensor_tile_sched;
  localparam logic [31:0] BA = 32'h1000;
  localparam logic [31:0] BB = 32'h2000;
  localparam logic [31:0] BC = 32'h3000;
  localparam logic [31:0] BD = 32'h4000;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] cfg_base_addr_A = BA, cfg_base_addr_B = BB, cfg_base_addr_C = BC, cfg_base_addr_D = BD;
  logic [7:0]  cfg_m = 8'd1, cfg_n = 8'd1, cfg_k = 8'd1;
  logic        cfg_start = 1'b0;
  logic        cmd_valid, cmd_ready = 1'b1;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [1:0]  cmd_type;
  logic        core_done = 1'b0, wr_done = 1'b0;
  logic        busy, done, err;

  always #5 aclk = ~aclk;

  tensor_tile_sched dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_base_addr_A(cfg_base_addr_A), .cfg_base_addr_B(cfg_base_addr_B),
    .cfg_base_addr_C(cfg_base_addr_C), .cfg_base_addr_D(cfg_base_addr_D),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k), .cfg_start(cfg_start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_type(cmd_type), .core_done(core_done),
    .wr_done(wr_done), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  typ;
  } desc_t;

  desc_t exp_q[$];
  int    pass_cnt = 0, chk_cnt = 0;
  int    n_xfer = 0, d_seen = 0, n_done = 0;
  int    wr_sent = 0, idle_cnt = 0, stall_len = 0;
  logic  bp_en = 1'b0, auto_core = 1'b0, auto_wr = 1'b0, wr_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
  endtask

  task automatic push(input logic [31:0] addr, input logic [1:0] typ);
    desc_t d;
    d.addr = addr;
    d.typ  = typ;
    exp_q.push_back(d);
  endtask

  task automatic push_job(input int m, input int n, input int k);
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        push(BC + 32'((r * n + c) * 256), 2'd2);
        for (int q = 0; q < k; q++) begin
          push(BA + 32'((r * k + q) * 256), 2'd0);
          push(BB + 32'((q * n + c) * 256), 2'd1);
        end
        push(BD + 32'((r * n + c) * 256), 2'd3);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold-during-stall.
  initial begin
    desc_t       e;
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic [1:0]  prev_type;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_type  = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(cmd_valid), 32'd1);
          check("hold_addr", cmd_addr, prev_addr);
          check("hold_type", 32'(cmd_type), 32'(prev_type));
        end
        if (cmd_valid && cmd_ready) begin
          n_xfer++;
          if (cmd_type == 2'd3) d_seen++;
          check("desc_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("desc_addr", cmd_addr, e.addr);
            check("desc_type", 32'(cmd_type), 32'(e.typ));
            check("desc_len", 32'(cmd_len), 32'd7);
          end
        end
        if (done) begin
          n_done++;
          check("busy_low_at_done", 32'(busy), 32'd0);
        end
        prev_stall = cmd_valid && !cmd_ready;
        prev_addr  = cmd_addr;
        prev_type  = cmd_type;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    core_done = 1'b0;
    wr_done   = 1'b0;
    if (bp_en) begin
      if (stall_len >= 5 || $urandom_range(0, 1) == 0) begin
        cmd_ready = 1'b1;
        stall_len = 0;
      end else begin
        cmd_ready = 1'b0;
        stall_len++;
      end
    end
    if (auto_core && busy && !cmd_valid) idle_cnt++;
    else idle_cnt = 0;
    if (idle_cnt == 3) core_done = 1'b1;
    if (auto_wr && !wr_last && d_seen > wr_sent) begin
      wr_done = 1'b1;
      wr_sent++;
    end
    wr_last = wr_done;
  endtask

  task automatic start_job(input logic [7:0] m, input logic [7:0] n, input logic [7:0] k);
    cfg_m     = m;
    cfg_n     = n;
    cfg_k     = k;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic run_to_done(input string name, input int bound);
    int nd0;
    bit seen;
    nd0  = n_done;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (n_done != nd0) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_d(input string name, input int target, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (d_seen >= target) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_valid"}, 32'(cmd_valid), 32'd0);
    check({name, "_addr"}, cmd_addr, 32'd0);
    check({name, "_len"}, 32'(cmd_len), 32'd0);
    check({name, "_type"}, 32'(cmd_type), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int  nx0, nd0, d0;
    bit  found;

    // Reset state
    aresetn = 1'b0;
    tick();
    tick();
    check_outputs_zero("reset");
    aresetn = 1'b1;
    tick();

    // Minimal job, manual core_done / wr_done
    push(32'h3000, 2'd2);
    push(32'h1000, 2'd0);
    push(32'h2000, 2'd1);
    push(32'h4000, 2'd3);
    nx0 = n_xfer;
    nd0 = n_done;
    d0  = d_seen;
    start_job(8'd1, 8'd1, 8'd1);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    check("t1_valid_after_start", 32'(cmd_valid), 32'd1);
    check("t1_first_type", 32'(cmd_type), 32'd2);
    check("t1_first_addr", cmd_addr, 32'h3000);
    repeat (8) tick();
    check("t1_idle_before_core", 32'(cmd_valid), 32'd0);
    check("t1_xfers_before_core", 32'(n_xfer - nx0), 32'd3);
    core_done = 1'b1;
    tick();
    wait_d("t1_d_issued", d0 + 1, 10);
    repeat (5) tick();
    check("t1_drain_busy", 32'(busy), 32'd1);
    check("t1_no_done_in_drain", 32'(n_done - nd0), 32'd0);
    wr_done = 1'b1;
    tick();
    check("t1_done_not_yet", 32'(done), 32'd0);
    tick();
    check("t1_done_pulse", 32'(done), 32'd1);
    check("t1_busy_fall", 32'(busy), 32'd0);
    tick();
    check("t1_done_one_cycle", 32'(done), 32'd0);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Address math Mt=2 Nt=1 Kt=2, hand-computed sequence
    auto_core = 1'b1;
    auto_wr   = 1'b1;
    wr_sent   = d_seen;
    for (int pass = 0; pass < 2; pass++) begin
      push(32'h3000, 2'd2); push(32'h1000, 2'd0); push(32'h2000, 2'd1);
      push(32'h1100, 2'd0); push(32'h2100, 2'd1); push(32'h4000, 2'd3);
      push(32'h3100, 2'd2); push(32'h1200, 2'd0); push(32'h2000, 2'd1);
      push(32'h1300, 2'd0); push(32'h2100, 2'd1); push(32'h4100, 2'd3);
      d0    = d_seen;
      bp_en = (pass == 1);
      start_job(8'd2, 8'd1, 8'd2);
      run_to_done(pass == 0 ? "t2_done" : "t3_bp_done", 800);
      check(pass == 0 ? "t2_d_count" : "t3_d_count", 32'(d_seen - d0), 32'd2);
      bp_en     = 1'b0;
      cmd_ready = 1'b1;
      tick();
    end

    // Early core_done while in ISSUE_A
    auto_core = 1'b0;
    push_job(1, 1, 2);
    d0 = d_seen;
    start_job(8'd1, 8'd1, 8'd2);
    tick();
    check("t4_in_issue_a_valid", 32'(cmd_valid), 32'd1);
    check("t4_in_issue_a_type", 32'(cmd_type), 32'd0);
    core_done = 1'b1;
    tick();
    wait_d("t4_d_without_wait", d0 + 1, 15);
    run_to_done("t4_done", 50);
    auto_core = 1'b1;

    // Coincident wr_done on a D accept, then withheld wr_done in DRAIN
    auto_wr = 1'b0;
    push_job(1, 2, 1);
    d0  = d_seen;
    nd0 = n_done;
    start_job(8'd1, 8'd2, 8'd1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (cmd_valid && cmd_type == 2'd3) found = 1'b1;
      else tick();
    end
    check("t5_first_d_seen", 32'(found), 32'd1);
    wr_done = 1'b1;
    tick();
    wait_d("t5_second_d", d0 + 2, 40);
    repeat (10) tick();
    check("t5_drain_busy", 32'(busy), 32'd1);
    check("t5_no_done_withheld", 32'(n_done - nd0), 32'd0);
    wr_done = 1'b1;
    run_to_done("t5_done_after_wr", 5);

    // Zero dimension error, then clearing start
    nx0 = n_xfer;
    nd0 = n_done;
    start_job(8'd1, 8'd1, 8'd0);
    check("t6_err_set", 32'(err), 32'd1);
    check("t6_done_pulse", 32'(done), 32'd1);
    check("t6_busy_low", 32'(busy), 32'd0);
    tick();
    check("t6_done_cleared", 32'(done), 32'd0);
    check("t6_err_sticky", 32'(err), 32'd1);
    repeat (5) tick();
    check("t6_no_descriptors", 32'(n_xfer - nx0), 32'd0);
    check("t6_single_done", 32'(n_done - nd0), 32'd1);
    check("t6_busy_never", 32'(busy), 32'd0);
    auto_wr = 1'b1;
    wr_sent = d_seen;
    push_job(1, 1, 1);
    start_job(8'd1, 8'd1, 8'd1);
    check("t6_err_cleared", 32'(err), 32'd0);
    check("t6_busy_valid_start", 32'(busy), 32'd1);
    run_to_done("t6_done", 60);

    // Reset during ISSUE_B, then full restart with an ignored start while busy
    push_job(1, 1, 2);
    start_job(8'd1, 8'd1, 8'd2);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (cmd_valid && cmd_type == 2'd1) found = 1'b1;
      else tick();
    end
    check("t7_reached_issue_b", 32'(found), 32'd1);
    cmd_ready = 1'b0;
    aresetn   = 1'b0;
    tick();
    check_outputs_zero("t7_midjob_reset");
    aresetn   = 1'b1;
    cmd_ready = 1'b1;
    exp_q.delete();
    tick();
    wr_sent = d_seen;
    push_job(2, 2, 1);
    nx0 = n_xfer;
    nd0 = n_done;
    start_job(8'd2, 8'd2, 8'd1);
    tick();
    tick();
    cfg_m     = 8'd5;
    cfg_k     = 8'd3;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    run_to_done("t7_restart_done", 400);
    check("t7_xfer_count", 32'(n_xfer - nx0), 32'd16);
    check("t7_single_done", 32'(n_done - nd0), 32'd1);
    repeat (5) tick();
    check("t7_idle_after", 32'(busy), 32'd0);
    check("t7_no_stray_xfer", 32'(n_xfer - nx0), 32'd16);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
